qdrc_phy_bit_train: RTL and testbench
=====================================

# qdrc_phy_bit_train

Per-bit read-data calibration engine for the QDR PHY read path. While a known training pattern is read back, the block sweeps the bit's input delay line, finds the widest stable data eye, and parks the delay at its centre. It then measures the rise/fall phase and drives `aligned` into the downstream bit-correction stage, which uses it to select between same-cycle and half-cycle-shifted data. One instance per DQ bit, in the clk0 domain.

## Interface
- `TAPS`, 64: delay-line taps swept (0..TAPS-1).
- `TAP_W`, 6: width of tap counters, with `2**TAP_W >= TAPS`.
- `SETTLE_CYCLES`, 8: wait cycles after any delay change before sampling.
- `SAMPLE_CYCLES`, 16: samples checked per tap.
- `WIN_MIN`, 4: minimum eye width in taps for a pass.

Ports:
- `clk0` in 1: PHY clock; all logic on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cal_start` in 1: level/pulse; starts calibration from IDLE, DONE or FAIL.
- `qdr_q_rise` in 1: registered rise data, clk0 domain.
- `qdr_q_fall` in 1: registered fall data, clk0 domain.
- `dly_rst` out 1: one-cycle pulse; resets the delay line to tap 0.
- `dly_inc` out 1: one-cycle pulse; advances the delay line by one tap.
- `tap_value` out TAP_W: block's model of the current delay tap.
- `aligned` out 1: 1 means rise carries the first beat; 0 means swapped.
- `cal_done` out 1: calibration passed; held until restart or reset.
- `cal_fail` out 1: calibration failed; held until restart or reset.

## Operation
- Training stream: the memory returns a 1,0 beat pair every cycle. At a stable tap, `{rise,fall}` is therefore constant and `rise != fall`.
- States: IDLE, RST, SETTLE, SAMPLE, NEXT, CENTER_RST, CENTER_INC, CENTER_SETTLE, PHASE, DONE, FAIL.
- **IDLE / DONE / FAIL**: when `cal_start=1`, clear `cal_done`, `cal_fail`, `aligned` and the run trackers, then go to RST.
- **RST**: assert `dly_rst` for 1 cycle, set `tap_value=0`, then go to SETTLE.
- **SETTLE**: count `SETTLE_CYCLES` cycles, then go to SAMPLE.
- **SAMPLE**:
  - The first cycle latches the reference pair.
  - The next `SAMPLE_CYCLES-1` cycles compare against it.
  - The tap is stable iff every pair equals the reference and `ref[1]^ref[0]=1`.
- **NEXT** (1 cycle):
  - Update the run trackers:
    - Stable tap: if `cur_len==0`, set `cur_start=tap`; then increment `cur_len`.
    - Unstable tap: close the run. If `cur_len > best_len` (strictly greater), copy it to best. Clear `cur_len`.
  - If `tap==TAPS-1`: close any open run the same way, then evaluate.
    - `best_len < WIN_MIN` → FAIL.
    - Otherwise `target = best_start + (best_len>>1)` (floor) → CENTER_RST.
  - Else: pulse `dly_inc`, increment `tap_value`, go to SETTLE.
- **CENTER_RST**: pulse `dly_rst`, set `tap_value=0`.
  - If `target==0`, go to CENTER_SETTLE.
  - Else go to CENTER_INC.
- **CENTER_INC**: one `dly_inc` pulse per cycle, incrementing `tap_value`, until `tap_value==target`; then go to CENTER_SETTLE.
- **CENTER_SETTLE**: `SETTLE_CYCLES` cycles, then go to PHASE.
- **PHASE**: sample `SAMPLE_CYCLES` cycles with the same stability test.
  - Stable with ref 2'b10: `aligned=1`, go to DONE.
  - Stable with ref 2'b01: `aligned=0`, go to DONE.
  - Otherwise go to FAIL.
- **DONE**: `cal_done=1`. **FAIL**: `cal_fail=1`, `aligned=0`, delay left at its last tap.
- `cal_start` is ignored in every state other than IDLE, DONE and FAIL.

## Timing
- Reset values: all outputs 0, state IDLE, all counters and trackers 0.
- Reset asserted mid-operation: immediate async return to IDLE. No `dly_rst` is issued; the next `cal_start` begins with RST.
- `cal_start` sampled in IDLE → `dly_rst` high on the next cycle.
- Per-tap cost: `1 + SETTLE_CYCLES + SAMPLE_CYCLES` cycles (NEXT + SETTLE + SAMPLE).
- Tap 0 adds the initial RST cycle.
- Full sweep with defaults: 1 + 64×25 = 1601 cycles to the final NEXT.
- `dly_inc` and `dly_rst` are never high together. `dly_inc` is never high in SAMPLE or SETTLE.
- `aligned` is valid only while `cal_done=1`. Downstream must ignore it otherwise.
- `cal_done` and `cal_fail` are mutually exclusive and assert in the cycle after the PHASE/NEXT decision.
- `tap_value` always equals the number of `dly_inc` pulses since the last `dly_rst`.

## Test plan
Bench models the delay line: a tap counter driven by `dly_rst`/`dly_inc`, and a per-tap pattern table returning the rise/fall pair, or random toggling for unstable taps.
- All 64 taps stable at 2'b10 → best 0/64, target 32, 32 `dly_inc` after the final `dly_rst`, `aligned=1`, `cal_done=1`.
- Taps 10..29 stable at 2'b01, rest toggling → target 20, `tap_value=20`, `aligned=0`, `cal_done=1`.
- Windows at taps 5..9 and 40..51 → second window chosen, target 46, `cal_done=1`.
- Equal windows at 0..7 and 50..57 → first kept (strict compare), target 4.
- Longest window 3 taps, or centre tap returns 2'b11 in PHASE → `cal_fail=1`, `cal_done=0`, `aligned=0`.
- `reset_n` pulsed low at tap 30 → all outputs 0 immediately. A new `cal_start` restarts with a `dly_rst` pulse. `cal_start` pulsed mid-sweep → no effect on the sequence.

Source files
------------

// File: rtl/qdrc_phy_bit_train.sv
// Per-bit read calibration: sweeps the input delay line over a 1,0 training stream,
// parks the tap at the centre of the widest stable eye, then resolves rise/fall phase.
module qdrc_phy_bit_train #(
  parameter int TAPS          = 64,
  parameter int TAP_W         = 6,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLE_CYCLES = 16,
  parameter int WIN_MIN       = 4
) (
  input  logic             clk0,
  input  logic             reset_n,
  input  logic             cal_start,
  input  logic             qdr_q_rise,
  input  logic             qdr_q_fall,
  output logic             dly_rst,
  output logic             dly_inc,
  output logic [TAP_W-1:0] tap_value,
  output logic             aligned,
  output logic             cal_done,
  output logic             cal_fail
);

  localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
  localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(TAPS - 1);
  localparam logic [TAP_W:0]   WIN_MIN_L   = (TAP_W+1)'(WIN_MIN);

  typedef enum logic [3:0] {
    IDLE, RST, SETTLE, SAMPLE, NEXT, CENTER_RST, CENTER_INC,
    CENTER_SETTLE, PHASE, DONE, FAIL
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       ref_pair;
  logic             pair_ok;
  logic [TAP_W-1:0] cur_start, best_start, target;
  logic [TAP_W:0]   cur_len, best_len;

  logic [1:0]       pair, samp_ref;
  logic             samp_ok, samp_stable, tap_stable;
  logic             settle_last, sample_last, last_tap, close_run, take_best, win_ok;
  logic [TAP_W:0]   run_len, new_best_len;
  logic [TAP_W-1:0] run_start, new_best_start, center;

  assign pair        = {qdr_q_rise, qdr_q_fall};
  assign settle_last = (cnt == SETTLE_LAST);
  assign sample_last = (cnt == SAMPLE_LAST);

  // The first sample cycle takes the incoming pair as reference, later ones compare.
  assign samp_ref    = (cnt == '0) ? pair : ref_pair;
  assign samp_ok     = (cnt == '0) ? 1'b1 : (pair_ok & (pair == ref_pair));
  assign samp_stable = samp_ok & (samp_ref[1] ^ samp_ref[0]);
  assign tap_stable  = pair_ok & (ref_pair[1] ^ ref_pair[0]);

  // On the last tap an open run is closed in the same cycle it is extended.
  assign last_tap       = (tap_value == LAST_TAP);
  assign run_len        = tap_stable ? (cur_len + (TAP_W+1)'(1)) : cur_len;
  assign run_start      = (tap_stable && (cur_len == '0)) ? tap_value : cur_start;
  assign close_run      = !tap_stable || last_tap;
  assign take_best      = close_run && (run_len > best_len);
  assign new_best_len   = take_best ? run_len : best_len;
  assign new_best_start = take_best ? run_start : best_start;
  assign center         = new_best_start + TAP_W'(new_best_len >> 1);
  assign win_ok         = (new_best_len >= WIN_MIN_L);

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dly_rst   = 1'b0;
    dly_inc   = 1'b0;
    case (state)
      IDLE, DONE, FAIL: if (cal_start) state_nxt = RST;
      RST: begin
        dly_rst   = 1'b1;
        state_nxt = SETTLE;
      end
      SETTLE: if (settle_last) state_nxt = SAMPLE;
      SAMPLE: if (sample_last) state_nxt = NEXT;
      NEXT: begin
        if (last_tap) begin
          state_nxt = win_ok ? CENTER_RST : FAIL;
        end else begin
          dly_inc   = 1'b1;
          state_nxt = SETTLE;
        end
      end
      CENTER_RST: begin
        dly_rst   = 1'b1;
        state_nxt = (target == '0) ? CENTER_SETTLE : CENTER_INC;
      end
      CENTER_INC: begin
        dly_inc = 1'b1;
        if ((tap_value + TAP_W'(1)) == target) state_nxt = CENTER_SETTLE;
      end
      CENTER_SETTLE: if (settle_last) state_nxt = PHASE;
      PHASE: if (sample_last) state_nxt = samp_stable ? DONE : FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk0 or negedge reset_n) begin
    if (!reset_n) begin
      cnt        <= '0;
      ref_pair   <= '0;
      pair_ok    <= 1'b0;
      cur_start  <= '0;
      cur_len    <= '0;
      best_start <= '0;
      best_len   <= '0;
      target     <= '0;
      tap_value  <= '0;
      aligned    <= 1'b0;
      cal_done   <= 1'b0;
      cal_fail   <= 1'b0;
    end else begin
      if ((state == SETTLE || state == CENTER_SETTLE || state == SAMPLE || state == PHASE)
          && state_nxt == state)
        cnt <= cnt + CNT_W'(1);
      else
        cnt <= '0;

      case (state)
        IDLE, DONE, FAIL: begin
          if (cal_start) begin
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
            aligned    <= 1'b0;
            cur_start  <= '0;
            cur_len    <= '0;
            best_start <= '0;
            best_len   <= '0;
            target     <= '0;
          end
        end
        RST, CENTER_RST: tap_value <= '0;
        SAMPLE: begin
          ref_pair <= samp_ref;
          pair_ok  <= samp_ok;
        end
        NEXT: begin
          cur_start  <= run_start;
          cur_len    <= close_run ? '0 : run_len;
          best_start <= new_best_start;
          best_len   <= new_best_len;
          if (last_tap) begin
            if (win_ok) target <= center;
            else        cal_fail <= 1'b1;
          end else begin
            tap_value <= tap_value + TAP_W'(1);
          end
        end
        CENTER_INC: tap_value <= tap_value + TAP_W'(1);
        PHASE: begin
          ref_pair <= samp_ref;
          pair_ok  <= samp_ok;
          if (sample_last) begin
            if (samp_stable) begin
              cal_done <= 1'b1;
              aligned  <= (samp_ref == 2'b10);
            end else begin
              cal_fail <= 1'b1;
              aligned  <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qdrc_phy_bit_train.sv
// Bench for qdrc_phy_bit_train: models the delay line plus a per-tap training pattern
// table and predicts the chosen eye, centre tap, phase and completion latency.
module tb_qdrc_phy_bit_train;

  localparam int TAPS    = 64;
  localparam int TAP_W   = 6;
  localparam int SETTLE  = 8;
  localparam int SAMPLE  = 16;
  localparam int WIN_MIN = 4;

  logic             clk0 = 1'b0;
  logic             reset_n = 1'b1;
  logic             cal_start = 1'b0;
  logic             qdr_q_rise = 1'b0;
  logic             qdr_q_fall = 1'b0;
  logic             dly_rst, dly_inc, aligned, cal_done, cal_fail;
  logic [TAP_W-1:0] tap_value;

  qdrc_phy_bit_train #(
    .TAPS(TAPS), .TAP_W(TAP_W), .SETTLE_CYCLES(SETTLE),
    .SAMPLE_CYCLES(SAMPLE), .WIN_MIN(WIN_MIN)
  ) dut (
    .clk0(clk0), .reset_n(reset_n), .cal_start(cal_start),
    .qdr_q_rise(qdr_q_rise), .qdr_q_fall(qdr_q_fall),
    .dly_rst(dly_rst), .dly_inc(dly_inc), .tap_value(tap_value),
    .aligned(aligned), .cal_done(cal_done), .cal_fail(cal_fail)
  );

  always #5 clk0 = ~clk0;

  logic [1:0] pat [TAPS];
  logic       toggle [TAPS];
  logic       ovr_en = 1'b0;
  int         ovr_tap = 0;
  logic [1:0] ovr_val = 2'b00;

  int   mtap = 0, rst_seen = 0, inc_since_rst = 0, both_err = 0, tap_err = 0;
  logic track_en = 1'b0;
  int   checks = 0, errors = 0;

  // Delay-line model: pulses seen in a cycle move the tap for the next cycle's data.
  always @(negedge clk0) begin
    if (track_en && reset_n && int'(tap_value) != mtap) tap_err++;
    if (dly_rst && dly_inc) both_err++;
    if (dly_rst) begin
      mtap = 0; rst_seen++; inc_since_rst = 0; track_en = 1'b1;
    end else if (dly_inc) begin
      mtap = (mtap + 1) % TAPS; inc_since_rst++;
    end
    if (ovr_en && rst_seen >= 2 && mtap == ovr_tap) {qdr_q_rise, qdr_q_fall} = ovr_val;
    else if (toggle[mtap])                          {qdr_q_rise, qdr_q_fall} = 2'($urandom);
    else                                            {qdr_q_rise, qdr_q_fall} = pat[mtap];
  end

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit good(input int t);
    return !toggle[t] && (pat[t] == 2'b10 || pat[t] == 2'b01);
  endfunction

  // Reference: widest run of good taps (earliest on ties), centre, phase at centre.
  task automatic model(output bit e_done, output bit e_al, output int e_tap,
                       output int e_lat, output int e_incs);
    int best_s, best_l, t, s;
    logic [1:0] ph;
    best_s = 0; best_l = 0; t = 0;
    while (t < TAPS) begin
      if (good(t)) begin
        s = t;
        while (t < TAPS && good(t)) t++;
        if (t - s > best_l) begin best_s = s; best_l = t - s; end
      end else t++;
    end
    if (best_l < WIN_MIN) begin
      e_done = 0; e_al = 0; e_tap = TAPS - 1; e_incs = TAPS - 1;
      e_lat = 1 + TAPS * (1 + SETTLE + SAMPLE);
    end else begin
      e_tap  = best_s + best_l / 2;
      e_incs = e_tap;
      e_lat  = 1 + TAPS * (1 + SETTLE + SAMPLE) + 1 + e_tap + SETTLE + SAMPLE;
      ph     = (ovr_en && ovr_tap == e_tap) ? ovr_val : pat[e_tap];
      e_done = (ph == 2'b10 || ph == 2'b01);
      e_al   = (ph == 2'b10);
    end
  endtask

  task automatic clear_table(input bit tog);
    for (int i = 0; i < TAPS; i++) begin pat[i] = 2'b10; toggle[i] = tog; end
    ovr_en = 1'b0;
  endtask

  task automatic set_run(input int s, input int e, input logic [1:0] v);
    for (int i = s; i <= e && i < TAPS; i++) begin pat[i] = v; toggle[i] = 1'b0; end
  endtask

  // Runs one calibration; glitch_at > 0 pulses cal_start that many cycles into it.
  task automatic applyStimulus(input string name, input int glitch_at);
    bit e_done, e_al, got;
    int e_tap, e_lat, e_incs, lat;
    model(e_done, e_al, e_tap, e_lat, e_incs);
    @(negedge clk0); #1;
    both_err = 0; tap_err = 0; rst_seen = 0;
    cal_start = 1'b1;
    @(negedge clk0);
    checkOutput({name, ":rst_pulse"}, dly_rst, 1);
    cal_start = 1'b0;
    lat = 0; got = 0;
    while (lat < 4000 && !got) begin
      @(negedge clk0);
      lat++;
      cal_start = (lat == glitch_at);
      if (cal_done || cal_fail) got = 1;
    end
    cal_start = 1'b0;
    checkOutput({name, ":finished"}, got, 1);
    checkOutput({name, ":latency"}, lat, e_lat);
    checkOutput({name, ":cal_done"}, cal_done, e_done);
    checkOutput({name, ":cal_fail"}, cal_fail, !e_done);
    checkOutput({name, ":aligned"}, aligned, e_al);
    checkOutput({name, ":tap_value"}, tap_value, e_tap);
    checkOutput({name, ":incs"}, inc_since_rst, e_incs);
    checkOutput({name, ":rst_inc_overlap"}, both_err, 0);
    checkOutput({name, ":tap_track"}, tap_err, 0);
    repeat (5) @(negedge clk0);
    checkOutput({name, ":hold"}, {cal_done, cal_fail}, {e_done, !e_done});
  endtask

  initial begin
    int w;
    clear_table(1'b0);
    #2 reset_n = 1'b0;
    #1 checkOutput("reset_outs", {dly_rst, dly_inc, tap_value, aligned, cal_done, cal_fail}, 0);
    repeat (3) @(negedge clk0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk0);
    checkOutput("idle_quiet", {dly_rst, dly_inc, cal_done, cal_fail}, 0);

    clear_table(1'b0);
    applyStimulus("all_stable_10", 0);

    clear_table(1'b1); set_run(10, 29, 2'b01);
    applyStimulus("win_10_29", 0);

    clear_table(1'b1); set_run(5, 9, 2'b10); set_run(40, 51, 2'b10);
    applyStimulus("two_windows", 0);

    clear_table(1'b1); set_run(0, 7, 2'b01); set_run(50, 57, 2'b10);
    applyStimulus("equal_windows", 0);

    clear_table(1'b1); set_run(10, 12, 2'b10); set_run(20, 22, 2'b01);
    applyStimulus("narrow_fail", 0);

    clear_table(1'b1); set_run(10, 29, 2'b10);
    ovr_en = 1'b1; ovr_tap = 20; ovr_val = 2'b11;
    applyStimulus("phase_fail", 0);

    clear_table(1'b1); set_run(5, 9, 2'b10); set_run(40, 51, 2'b01);
    applyStimulus("start_glitch", 500);

    // Async reset partway through a sweep
    clear_table(1'b0);
    @(negedge clk0); #1 cal_start = 1'b1;
    @(negedge clk0); #1 cal_start = 1'b0;
    w = 0;
    while (mtap < 30 && w < 2000) begin @(negedge clk0); #1; w++; end
    checkOutput("rst_mid:reach30", mtap >= 30, 1);
    #2 reset_n = 1'b0; track_en = 1'b0;
    #1 checkOutput("rst_mid:outs", {dly_rst, dly_inc, tap_value, aligned, cal_done, cal_fail}, 0);
    @(negedge clk0); #1 reset_n = 1'b1;
    repeat (3) @(negedge clk0);
    checkOutput("rst_mid:idle", {dly_rst, dly_inc, cal_done, cal_fail}, 0);
    clear_table(1'b1); set_run(10, 29, 2'b01);
    applyStimulus("after_reset", 0);

    // Random eye layouts
    for (int it = 0; it < 6; it++) begin
      int k, s, l;
      clear_table(1'b1);
      k = $urandom_range(1, 3);
      for (int r = 0; r < k; r++) begin
        s = $urandom_range(0, TAPS - 1);
        l = $urandom_range(1, 20);
        set_run(s, s + l - 1, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01);
      end
      for (int r = 0; r < 2; r++) begin
        s = $urandom_range(0, TAPS - 1);
        pat[s] = 2'b11; toggle[s] = 1'b0;
      end
      applyStimulus($sformatf("random%0d", it), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
